// File: rtl/seg7_scan_capture_if.sv
// Bus bundle for the 7-segment scan capture block.
// The display-side driver owns seg_in/dig_sel.
// The capture block owns the recovered frame outputs.
interface seg7_scan_capture_if #(
  parameter int DIGITS = 4
) ();

  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   digit_err;
  logic                frame_valid;
  logic                busy;

  modport master (
    output seg_in,
    output dig_sel,
    input  bcd_out,
    input  digit_err,
    input  frame_valid,
    input  busy
  );

  modport slave (
    input  seg_in,
    input  dig_sel,
    output bcd_out,
    output digit_err,
    output frame_valid,
    output busy
  );

endinterface

// File: rtl/seg7_scan_capture.sv
// Receive side of a multiplexed 7-segment display.
// Watches the segment bus and the one-hot digit strobe, and recovers the BCD
// value shown on each position. A position is captured only after its pattern
// has held steady for STABLE_CYCLES samples. Once every position has been
// captured, the whole frame is published with a one-cycle frame_valid pulse.
module seg7_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_capture_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT,
    TRACK,
    HELD
  } state_t;

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            SINGLE   = (STABLE_CYCLES == 1);

  state_t              state;
  state_t              state_next;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_next;
  logic [6:0]          stored_seg;
  logic [DIGITS-1:0]   stored_sel;
  logic                load;
  logic                capture;
  logic                sample_valid;
  logic                sample_same;
  logic                commit;
  logic [3:0]          dec_val;
  logic                dec_err;
  logic [DIGITS-1:0]   captured_mask;
  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   shadow_err;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   err_q;
  logic                fv_q;

  // A sample is usable only when exactly one digit strobe is active.
  assign sample_valid = (bus.dig_sel != '0) &&
                        ((bus.dig_sel & (bus.dig_sel - DIGITS'(1))) == '0);
  assign sample_same  = sample_valid && (bus.seg_in == stored_seg) &&
                        (bus.dig_sel == stored_sel);
  assign commit       = &captured_mask;

  // Segment pattern to BCD; both common renderings of 7 and 9 are accepted.
  always_comb begin
    dec_val = 4'hE;
    dec_err = 1'b0;
    case (bus.seg_in)
      7'h3F:        dec_val = 4'h0;
      7'h06:        dec_val = 4'h1;
      7'h5B:        dec_val = 4'h2;
      7'h4F:        dec_val = 4'h3;
      7'h66:        dec_val = 4'h4;
      7'h6D:        dec_val = 4'h5;
      7'h7D:        dec_val = 4'h6;
      7'h07, 7'h27: dec_val = 4'h7;
      7'h7F:        dec_val = 4'h8;
      7'h6F, 7'h67: dec_val = 4'h9;
      7'h00:        dec_val = 4'hF;
      default: begin
        dec_val = 4'hE;
        dec_err = 1'b1;
      end
    endcase
  end

  // Stability tracker: decides when a held sample has been seen long enough.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    capture    = 1'b0;
    unique case (state)
      WAIT: begin
        if (sample_valid) begin
          load     = 1'b1;
          cnt_next = CNT_ONE;
          if (SINGLE) begin
            capture    = 1'b1;
            state_next = HELD;
          end else begin
            state_next = TRACK;
          end
        end else begin
          cnt_next = '0;
        end
      end
      TRACK: begin
        if (!sample_valid) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else if (sample_same) begin
          if (cnt < CNT_MAX) begin
            cnt_next = cnt + CNT_ONE;
            if (cnt + CNT_ONE == CNT_MAX) begin
              capture    = 1'b1;
              state_next = HELD;
            end
          end
        end else begin
          load     = 1'b1;
          cnt_next = CNT_ONE;
          if (SINGLE) begin
            capture    = 1'b1;
            state_next = HELD;
          end else begin
            state_next = TRACK;
          end
        end
      end
      HELD: begin
        if (!sample_valid) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else if (!sample_same) begin
          load     = 1'b1;
          cnt_next = CNT_ONE;
          if (SINGLE) begin
            capture    = 1'b1;
            state_next = HELD;
          end else begin
            state_next = TRACK;
          end
        end
      end
      default: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and the reference sample being tracked.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT;
      cnt        <= '0;
      stored_seg <= '0;
      stored_sel <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        stored_seg <= bus.seg_in;
        stored_sel <= bus.dig_sel;
      end
    end
  end

  // Shadow frame: the latest capture for each position wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '1;
      shadow_err <= '0;
    end else if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (bus.dig_sel[i]) begin
          shadow[4*i +: 4] <= dec_val;
          shadow_err[i]    <= dec_err;
        end
      end
    end
  end

  // Frame publish: the old shadow is copied out, and a capture on the same edge starts the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      captured_mask <= '0;
      bcd_q         <= '1;
      err_q         <= '0;
      fv_q          <= 1'b0;
    end else begin
      fv_q          <= commit;
      captured_mask <= (commit ? '0 : captured_mask) |
                       (capture ? bus.dig_sel : '0);
      if (commit) begin
        bcd_q <= shadow;
        err_q <= shadow_err;
      end
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.digit_err   = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.busy        = |captured_mask;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with DIGITS=4 and STABLE_CYCLES=3.
// Inputs change on the falling edge, and outputs are observed on the falling edge.
module tb_seg7_scan_capture;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   fv_count;
  int   fv_base;

  seg7_scan_capture_if #(.DIGITS(4)) bus ();

  seg7_scan_capture #(
    .DIGITS        (4),
    .STABLE_CYCLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts frame_valid pulses so tests can assert how many frames committed.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) fv_count++;
  end

  // Drives one sample for n rising edges; called and returns on a falling edge.
  task automatic hold(input logic [6:0] s, input logic [3:0] sel, input int n);
    bus.seg_in  = s;
    bus.dig_sel = sel;
    repeat (n) @(negedge clk);
  endtask

  // Scans all four positions, three samples each.
  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    hold(s0, 4'b0001, 3);
    hold(s1, 4'b0010, 3);
    hold(s2, 4'b0100, 3);
    hold(s3, 4'b1000, 3);
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    bus.seg_in  = 7'h00;
    bus.dig_sel = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.bcd_out !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL reset_bcd got %h want ffff", bus.bcd_out);
    end
    checks++;
    if (bus.digit_err !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_err got %b want 0000", bus.digit_err);
    end
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags fv=%b busy=%b want 0 0", bus.frame_valid, bus.busy);
    end
  endtask

  task automatic test_basic_frame;
    fv_base = fv_count;
    hold(7'h3F, 4'b0001, 3);
    hold(7'h06, 4'b0010, 3);
    hold(7'h5B, 4'b0100, 3);
    checks++;
    if (bus.busy !== 1'b1 || bus.bcd_out !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL basic_partial busy=%b bcd=%h want 1 ffff", bus.busy, bus.bcd_out);
    end
    hold(7'h4F, 4'b1000, 3);
    hold(7'h00, 4'b0000, 2);
    checks++;
    if (fv_count - fv_base !== 1) begin
      errors++;
      $display("[TB] FAIL basic_fv got %0d want 1", fv_count - fv_base);
    end
    checks++;
    if (bus.bcd_out !== 16'h3210) begin
      errors++;
      $display("[TB] FAIL basic_bcd got %h want 3210", bus.bcd_out);
    end
    checks++;
    if (bus.digit_err !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_err_busy err=%b busy=%b want 0000 0", bus.digit_err, bus.busy);
    end
  endtask

  task automatic test_short_digit;
    fv_base = fv_count;
    hold(7'h6D, 4'b0001, 3);
    hold(7'h7D, 4'b0010, 3);
    hold(7'h5B, 4'b0100, 2);
    hold(7'h7F, 4'b1000, 3);
    hold(7'h00, 4'b0000, 3);
    checks++;
    if (fv_count - fv_base !== 0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_no_frame fv=%0d busy=%b want 0 1", fv_count - fv_base, bus.busy);
    end
    hold(7'h66, 4'b0100, 3);
    hold(7'h00, 4'b0000, 2);
    checks++;
    if (fv_count - fv_base !== 1) begin
      errors++;
      $display("[TB] FAIL short_fv got %0d want 1", fv_count - fv_base);
    end
    checks++;
    if (bus.bcd_out !== 16'h8465) begin
      errors++;
      $display("[TB] FAIL short_bcd got %h want 8465", bus.bcd_out);
    end
  endtask

  task automatic test_illegal_pattern;
    fv_base = fv_count;
    scan4(7'h3F, 7'h49, 7'h06, 7'h5B);
    hold(7'h00, 4'b0000, 2);
    checks++;
    if (fv_count - fv_base !== 1) begin
      errors++;
      $display("[TB] FAIL illegal_fv got %0d want 1", fv_count - fv_base);
    end
    checks++;
    if (bus.bcd_out !== 16'h21E0) begin
      errors++;
      $display("[TB] FAIL illegal_bcd got %h want 21e0", bus.bcd_out);
    end
    checks++;
    if (bus.digit_err !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL illegal_err got %b want 0010", bus.digit_err);
    end
  endtask

  task automatic test_invalid_strobe;
    fv_base = fv_count;
    hold(7'h4F, 4'b0001, 2);
    hold(7'h4F, 4'b0011, 1);
    hold(7'h4F, 4'b0001, 2);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL multihot_no_capture busy=%b want 0", bus.busy);
    end
    hold(7'h4F, 4'b0000, 1);
    hold(7'h4F, 4'b0001, 2);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zerohot_no_capture busy=%b want 0", bus.busy);
    end
    hold(7'h4F, 4'b0001, 1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL strobe_capture busy=%b want 1", bus.busy);
    end
    hold(7'h66, 4'b0010, 3);
    hold(7'h6F, 4'b0100, 3);
    hold(7'h00, 4'b1000, 3);
    hold(7'h00, 4'b0000, 2);
    checks++;
    if (fv_count - fv_base !== 1 || bus.bcd_out !== 16'hF943) begin
      errors++;
      $display("[TB] FAIL blank_bcd fv=%0d bcd=%h want 1 f943", fv_count - fv_base, bus.bcd_out);
    end
    checks++;
    if (bus.digit_err !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL blank_err got %b want 0000", bus.digit_err);
    end
  endtask

  task automatic test_alt_patterns_and_hold;
    fv_base = fv_count;
    hold(7'h27, 4'b0001, 3);
    hold(7'h67, 4'b0010, 3);
    hold(7'h07, 4'b0100, 20);
    checks++;
    if (fv_count - fv_base !== 0) begin
      errors++;
      $display("[TB] FAIL long_hold_early_fv got %0d want 0", fv_count - fv_base);
    end
    hold(7'h7F, 4'b1000, 23);
    checks++;
    if (fv_count - fv_base !== 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL long_hold_fv fv=%0d busy=%b want 1 0", fv_count - fv_base, bus.busy);
    end
    checks++;
    if (bus.bcd_out !== 16'h8797) begin
      errors++;
      $display("[TB] FAIL alt_bcd got %h want 8797", bus.bcd_out);
    end
    hold(7'h00, 4'b0000, 2);
  endtask

  task automatic test_midframe_reset;
    hold(7'h5B, 4'b0001, 3);
    hold(7'h4F, 4'b0010, 3);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_busy got %b want 1", bus.busy);
    end
    rst = 1'b1;
    hold(7'h00, 4'b0000, 1);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.bcd_out !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL midreset busy=%b bcd=%h want 0 ffff", bus.busy, bus.bcd_out);
    end
    fv_base = fv_count;
    scan4(7'h3F, 7'h06, 7'h5B, 7'h4F);
    hold(7'h00, 4'b0000, 2);
    checks++;
    if (fv_count - fv_base !== 1 || bus.bcd_out !== 16'h3210) begin
      errors++;
      $display("[TB] FAIL post_reset_frame fv=%0d bcd=%h want 1 3210", fv_count - fv_base, bus.bcd_out);
    end
  endtask

  task automatic test_back_to_back;
    fv_base = fv_count;
    scan4(7'h06, 7'h5B, 7'h4F, 7'h66);
    hold(7'h7D, 4'b0001, 3);
    checks++;
    if (fv_count - fv_base !== 1 || bus.bcd_out !== 16'h4321) begin
      errors++;
      $display("[TB] FAIL b2b_first fv=%0d bcd=%h want 1 4321", fv_count - fv_base, bus.bcd_out);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_busy got %b want 1", bus.busy);
    end
    hold(7'h07, 4'b0010, 3);
    hold(7'h7F, 4'b0100, 3);
    hold(7'h6F, 4'b1000, 3);
    hold(7'h00, 4'b0000, 2);
    checks++;
    if (fv_count - fv_base !== 2 || bus.bcd_out !== 16'h9876) begin
      errors++;
      $display("[TB] FAIL b2b_second fv=%0d bcd=%h want 2 9876", fv_count - fv_base, bus.bcd_out);
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    checks      = 0;
    errors      = 0;
    fv_count    = 0;
    fv_base     = 0;
    rst         = 1'b1;
    bus.seg_in  = 7'h00;
    bus.dig_sel = 4'b0000;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_short_digit();
    test_illegal_pattern();
    test_invalid_strobe();
    test_alt_patterns_and_hold();
    test_midframe_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
